// File: rtl/pq_shift_array.sv
// pq_shift_array -- shift-register hardware priority queue of <key,value> pairs.
//
// The cells form a sorted array with the head at cell 0. Valid cells are
// contiguous from cell 0. Entries with equal keys leave in arrival order.
// Every operation finishes in one cycle. Each cell decides its next content
// from kv_in, its own contents and one neighbour.
//
// Parameters:
//   KEY_WIDTH  key (priority) width
//   VAL_WIDTH  value (payload) width
//   CAPACITY   number of cells (>= 1)
//   PQ_TYPE    0 = MIN_PQ (smallest key first), 1 = MAX_PQ (largest key first)
//
// Ports:
//   clk     rising-edge clock
//   rst_n   synchronous active-low reset
//   enq     enqueue request
//   kv_in   pair to enqueue, {key, value}
//   deq     dequeue request
//   kv_out  head pair from cell 0; shows {sentinel, 0} when empty
//   empty   count == 0
//   full    count == CAPACITY
//   count   number of occupied cells
//   err     (only with PQ_ERR_FLAGS_EN) bit0 sticky overflow, bit1 sticky underflow
//
// Optional feature macro: PQ_ERR_FLAGS_EN adds the err port and its sticky flags.
module pq_shift_array #(
  parameter int KEY_WIDTH = 8,
  parameter int VAL_WIDTH = 8,
  parameter int CAPACITY  = 15,
  parameter int PQ_TYPE   = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enq,
  input  logic [KEY_WIDTH+VAL_WIDTH-1:0] kv_in,
  input  logic                           deq,
  output logic [KEY_WIDTH+VAL_WIDTH-1:0] kv_out,
  output logic                           empty,
  output logic                           full,
  output logic [$clog2(CAPACITY+1)-1:0]  count
`ifdef PQ_ERR_FLAGS_EN
  ,
  output logic [1:0]                     err
`endif
);

  localparam int CNT_W = $clog2(CAPACITY + 1);
  localparam logic [KEY_WIDTH-1:0] SENTINEL =
    (PQ_TYPE == 0) ? {KEY_WIDTH{1'b1}} : {KEY_WIDTH{1'b0}};

  // Strict priority test: equal keys never precede, so a new entry lands
  // behind every existing entry with the same key.
  function automatic logic precedes(input logic [KEY_WIDTH-1:0] a,
                                    input logic [KEY_WIDTH-1:0] b);
    if (PQ_TYPE == 0) return a < b;
    else              return a > b;
  endfunction

  logic                 vld_q [CAPACITY];
  logic [KEY_WIDTH-1:0] key_q [CAPACITY];
  logic [VAL_WIDTH-1:0] val_q [CAPACITY];
  logic [CNT_W-1:0]     count_q;

  logic                 vld_d [CAPACITY];
  logic [KEY_WIDTH-1:0] key_d [CAPACITY];
  logic [VAL_WIDTH-1:0] val_d [CAPACITY];

  // Cells extended with a permanently-invalid virtual tail cell at CAPACITY.
  logic                 vld_x [CAPACITY+1];
  logic [KEY_WIDTH-1:0] key_x [CAPACITY+1];
  logic [VAL_WIDTH-1:0] val_x [CAPACITY+1];
  // Copy of the previous cell for each cell (unused filler at the head).
  logic                 vld_p [CAPACITY];
  logic [KEY_WIDTH-1:0] key_p [CAPACITY];
  logic [VAL_WIDTH-1:0] val_p [CAPACITY];

  logic [CAPACITY:0]    ins;       // new entry goes ahead of cell i
  logic [CAPACITY-1:0]  ins_prev;  // ins[i-1]; 0 at the head
  logic [CAPACITY-1:0]  rep_gate;  // ins[i] for i > 0; 0 at the head

  logic [KEY_WIDTH-1:0] key_in;
  logic [VAL_WIDTH-1:0] val_in;
  logic                 do_enq, do_deq, do_rep;

  assign key_in = kv_in[KEY_WIDTH+VAL_WIDTH-1 -: KEY_WIDTH];
  assign val_in = kv_in[VAL_WIDTH-1:0];

  assign empty  = (count_q == '0);
  assign full   = (count_q == CNT_W'(CAPACITY));
  assign count  = count_q;
  assign kv_out = {key_q[0], val_q[0]};

  // enq & deq while empty falls through to a plain enqueue. Empty implies
  // not full because CAPACITY >= 1.
  assign do_rep = enq && deq && !empty;
  assign do_enq = enq && !do_rep && !full;
  assign do_deq = deq && !enq && !empty;

  always_comb begin
    for (int i = 0; i < CAPACITY; i++) begin
      vld_x[i] = vld_q[i];
      key_x[i] = key_q[i];
      val_x[i] = val_q[i];
    end
    vld_x[CAPACITY] = 1'b0;
    key_x[CAPACITY] = SENTINEL;
    val_x[CAPACITY] = '0;

    vld_p[0] = 1'b0;
    key_p[0] = SENTINEL;
    val_p[0] = '0;
    for (int i = 1; i < CAPACITY; i++) begin
      vld_p[i] = vld_q[i-1];
      key_p[i] = key_q[i-1];
      val_p[i] = val_q[i-1];
    end

    // Ordering uses the valid bit, so a real key equal to the sentinel
    // still sorts correctly against empty cells.
    for (int i = 0; i <= CAPACITY; i++)
      ins[i] = !vld_x[i] || precedes(key_in, key_x[i]);

    ins_prev[0] = 1'b0;
    rep_gate[0] = 1'b0;
    for (int i = 1; i < CAPACITY; i++) begin
      ins_prev[i] = ins[i-1];
      rep_gate[i] = ins[i];
    end
  end

  always_comb begin
    for (int i = 0; i < CAPACITY; i++) begin
      vld_d[i] = vld_q[i];
      key_d[i] = key_q[i];
      val_d[i] = val_q[i];
      if (do_enq) begin
        // Cells ahead of the insert point hold. The first cell at or behind
        // it takes kv_in, and the rest take their predecessor.
        if (ins[i]) begin
          if (ins_prev[i]) begin
            vld_d[i] = vld_p[i];
            key_d[i] = key_p[i];
            val_d[i] = val_p[i];
          end else begin
            vld_d[i] = 1'b1;
            key_d[i] = key_in;
            val_d[i] = val_in;
          end
        end
      end else if (do_deq) begin
        vld_d[i] = vld_x[i+1];
        key_d[i] = key_x[i+1];
        val_d[i] = val_x[i+1];
      end else if (do_rep) begin
        // Insert into the list cells[1..] shifted toward the head. The
        // shifted list at i is cell i+1, and its predecessor is cell i.
        if (!ins[i+1]) begin
          vld_d[i] = vld_x[i+1];
          key_d[i] = key_x[i+1];
          val_d[i] = val_x[i+1];
        end else if (!rep_gate[i]) begin
          vld_d[i] = 1'b1;
          key_d[i] = key_in;
          val_d[i] = val_in;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CAPACITY; i++) begin
        vld_q[i] <= 1'b0;
        key_q[i] <= SENTINEL;
        val_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      for (int i = 0; i < CAPACITY; i++) begin
        vld_q[i] <= vld_d[i];
        key_q[i] <= key_d[i];
        val_q[i] <= val_d[i];
      end
      if (do_enq)      count_q <= count_q + CNT_W'(1);
      else if (do_deq) count_q <= count_q - CNT_W'(1);
    end
  end

`ifdef PQ_ERR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err <= 2'b00;
    end else begin
      if (enq && !deq && full)  err[0] <= 1'b1;
      if (deq && !enq && empty) err[1] <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/pq_shift_array.md
# pq_shift_array

Parametrised shift-register hardware priority queue holding `<key,value>` pairs in a sorted cell array, head at cell 0. It generalises the team's fixed-format PQ types: key/value widths, capacity and MIN/MAX ordering are parameters. It adds single-cycle enqueue, dequeue and combined replace, with deterministic FIFO tie-breaking. It is the baseline HWPQ implementation that other study variants are compared against.

## Interface
- `KEY_WIDTH`, 8, key (priority) width in bits
- `VAL_WIDTH`, 8, value (payload) width in bits
- `CAPACITY`, 15, number of cells; legal range ≥1
- `PQ_TYPE`, 0, 0 = MIN_PQ (smallest key first), 1 = MAX_PQ (largest key first)

Ports:
- `clk`  in  1  the single clock; all state changes on its rising edge
- `rst_n`  in  1  reset, synchronous and active-low
- `enq`  in  1  enqueue request, sampled each rising edge
- `kv_in`  in  KEY_WIDTH+VAL_WIDTH  pair to enqueue; key in MSBs, value in LSBs
- `deq`  in  1  dequeue request, sampled each rising edge
- `kv_out`  out  KEY_WIDTH+VAL_WIDTH  head pair, driven from cell 0 register
- `empty`  out  1  count == 0
- `full`  out  1  count == CAPACITY
- `count`  out  $clog2(CAPACITY+1)  occupied cells
- `err`  out  2  only with `PQ_ERR_FLAGS_EN`; bit0 sticky overflow, bit1 sticky underflow

## Operation
- Each cell holds a valid bit plus a pair. Valid cells are contiguous from cell 0 and are sorted in priority order.
- `a` precedes `b` if:
  - MIN_PQ: `a.key < b.key`
  - MAX_PQ: `a.key > b.key`
- Equal keys: the older entry precedes. Each new entry is placed behind all existing entries of equal key (stable FIFO).
- Invalid cells hold sentinel key with value 0. Sentinel key is all-ones for MIN_PQ and all-zeros for MAX_PQ. Ordering uses valid bits only, so a real key equal to the sentinel is handled correctly.
- Operations, decoded each cycle from (`enq`, `deq`, `empty`, `full`):
  - IDLE (neither, or all requests ignored): state held.
  - ENQ (`enq`, !`deq`, !`full`): `kv_in` inserted at its sorted position; cells behind it shift one toward the tail; count+1.
  - DEQ (`deq`, !`enq`, !`empty`): cell 0 dropped; all cells shift one toward the head; last valid cell becomes invalid; count−1.
  - REPLACE (`enq` & `deq`, !`empty`): head dropped and `kv_in` inserted into the remaining list in one cycle; count unchanged. Legal when full.
  - `enq` & `deq` while empty: deq ignored, treated as ENQ; count becomes 1.
  - `enq` while full without `deq`: dropped, state unchanged.
  - `deq` while empty without `enq`: ignored, state unchanged.
- Each operation is a per-cell compare-and-mux, with no iteration. Each cell compares `kv_in` against itself and its neighbour.

## Timing
- Reset (`rst_n`=0 at a rising edge) overrides `enq`/`deq`. It forces:
  - all cells invalid with sentinel content
  - `count`=0, `empty`=1, `full`=0
  - `kv_out`={sentinel,0}
  - `err`=0
- Reset asserted mid-operation discards all contents. No partial update occurs.
- Latency: an operation sampled at edge N is visible on `kv_out`/`count`/`empty`/`full` after edge N. No extra pipeline.
- Throughput: one operation per cycle, sustained indefinitely. There is no ready/ack; callers use `full`/`empty` before requesting.
- `kv_out` is valid only when `empty`=0. When empty it shows the sentinel value.
- `count` never wraps. It saturates logically at 0 and CAPACITY because illegal requests are dropped.

## Configuration
- `PQ_ERR_FLAGS_EN` defined:
  - `err` port exists.
  - bit0 sets on ENQ-while-full without `deq`.
  - bit1 sets on DEQ-while-empty without `enq`.
  - Both bits are sticky until reset; they set on the edge the request is sampled.
- Not defined: the `err` port and its logic are absent. Dropped requests are silent; all other behaviour is identical.

## Test plan
- Reset, then MIN_PQ enqueue keys 5, 3, 9 on consecutive cycles → after third edge `kv_out` key=3, `count`=3. Three deqs → heads 5, 9, then `empty`=1.
- Enqueue (7,v=1), (7,v=2), (7,v=3), then 3 deqs → values emerge 1, 2, 3 (FIFO ties).
- Fill CAPACITY=15 with keys 1..15, then `enq` key 0 without `deq` → `full`=1, `count`=15, head still 1. With macro, `err`=2'b01.
- Full queue, `enq`=`deq`=1 with key 8 → head becomes 2, `count` stays 15. Subsequent deqs yield 2..7, 8, 8, 9..15.
- PQ_TYPE=1, enqueue 5, 3, 9 → head 9. Then `deq` on a single-entry queue followed by extra `deq` → `empty`=1, no state change. With macro, `err`=2'b10.
- Enqueue 4 entries, assert `rst_n`=0 together with `enq` → next cycle `count`=0, `empty`=1, `kv_out`={sentinel,0}.
